// File: rtl/snn_infer_sched_pkg.sv
// Shared definitions for the SNN inference scheduler.
// Holds the default network dimensions, the wait timeout and the scheduler state type.
package snn_infer_sched_pkg;

  localparam int unsigned N_IN_DEF    = 30;
  localparam int unsigned N_CLS_DEF   = 5;
  localparam int unsigned STEP_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ARGMAX = 3'd4,
    ST_DONE   = 3'd5,
    ST_DRAIN  = 3'd6,
    ST_ERR    = 3'd7
  } sched_state_t;

endpackage

// File: rtl/snn_argmax_seq.sv
// Sequential argmax over N_CLS saturating counters, one class per cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : 1-cycle pulse, restarts the scan (also cancels a scan in flight)
//   counts     : per-class counts, class 0 in the LSBs; must be stable during the scan
//   done       : 1-cycle pulse when index is final
//   index      : winning class; strict '>' keeps the lowest index on ties
module snn_argmax_seq #(
  parameter int unsigned N_CLS = 5,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N_CLS-1:0][CNT_W-1:0]     counts,
  output logic                            done,
  output logic [IDX_W-1:0]                index
);

  logic             running;
  logic [IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0] max_val;

  // Scan class scan_idx each cycle; running max starts at 0 so all-zero counts give class 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      scan_idx <= '0;
      max_val  <= '0;
      index    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running  <= 1'b1;
        scan_idx <= '0;
        max_val  <= '0;
        index    <= '0;
      end else if (running) begin
        if (counts[scan_idx] > max_val) begin
          max_val <= counts[scan_idx];
          index   <= scan_idx;
        end
        if (scan_idx == IDX_W'(N_CLS - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          scan_idx <= scan_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/snn_infer_sched.sv
// Sample-level scheduler for the ECG SNN: clears the net, feeds cfg_steps input frames,
// pulses net_start per step, accumulates per-class output spikes and reports the argmax.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   sample_start        : begin a sample (IDLE only); cfg_steps latched with it
//   sample_abort        : terminate current sample (drains the net if it is running)
//   in_valid/in_ready   : input frame handshake, in_bits is the frame
//   net_clear/net_start : 1-cycle strobes to the net; net_spikes_in is the frame held for it
//   net_done            : step complete, net_spikes_out valid
//   busy                : high whenever not IDLE
//   result_valid        : 1-cycle pulse with result_class/result_counts updated
//   err_timeout         : sticky net_done timeout, cleared by the next accepted sample_start
module snn_infer_sched
  import snn_infer_sched_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned N_CLS   = N_CLS_DEF,
  parameter int unsigned STEP_W  = STEP_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_start,
  input  logic [STEP_W-1:0]          cfg_steps,
  input  logic                       sample_abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_bits,
  output logic                       net_clear,
  output logic                       net_start,
  output logic [N_IN-1:0]            net_spikes_in,
  input  logic                       net_done,
  input  logic [N_CLS-1:0]           net_spikes_out,
  output logic                       busy,
  output logic                       result_valid,
  output logic [$clog2(N_CLS)-1:0]   result_class,
  output logic [N_CLS*CNT_W-1:0]     result_counts,
  output logic                       err_timeout
);

  localparam int unsigned IDX_W  = $clog2(N_CLS);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t                state;
  logic [STEP_W-1:0]           steps_cfg;
  logic [STEP_W-1:0]           step_cnt;
  logic [WAIT_W-1:0]           wait_cnt;
  logic [N_CLS-1:0][CNT_W-1:0] counts;
  logic                        am_start;
  logic                        am_done;
  logic [IDX_W-1:0]            am_index;
  logic                        wait_expired;
  logic                        last_step;

  assign in_ready     = (state == ST_FETCH);
  // Current cycle is the TIMEOUT-th cycle spent waiting for net_done.
  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign last_step    = ((step_cnt + STEP_W'(1)) == steps_cfg);

  snn_argmax_seq #(
    .N_CLS (N_CLS),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (am_start),
    .counts (counts),
    .done   (am_done),
    .index  (am_index)
  );

  // Scheduler FSM with registered strobes and counter datapath; sample_abort wins every branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      steps_cfg     <= '0;
      step_cnt      <= '0;
      wait_cnt      <= '0;
      counts        <= '0;
      am_start      <= 1'b0;
      net_clear     <= 1'b0;
      net_start     <= 1'b0;
      net_spikes_in <= '0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_class  <= '0;
      result_counts <= '0;
      err_timeout   <= 1'b0;
    end else begin
      net_clear    <= 1'b0;
      net_start    <= 1'b0;
      result_valid <= 1'b0;
      am_start     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (sample_start && !sample_abort) begin
            steps_cfg   <= cfg_steps;
            step_cnt    <= '0;
            counts      <= '0;
            err_timeout <= 1'b0;
            net_clear   <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          if (sample_abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (steps_cfg == '0) begin
            am_start <= 1'b1;
            state    <= ST_ARGMAX;
          end else begin
            state <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (sample_abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (in_valid) begin
            net_spikes_in <= in_bits;
            net_start     <= 1'b1;
            wait_cnt      <= '0;
            state         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (sample_abort) begin
            // A net_done arriving with the abort means the net is already idle.
            if (net_done) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
              state    <= ST_DRAIN;
            end
          end else if (net_done) begin
            for (int i = 0; i < int'(N_CLS); i++) begin
              if (net_spikes_out[i] && (counts[i] != CNT_MAX)) begin
                counts[i] <= counts[i] + CNT_W'(1);
              end
            end
            step_cnt <= step_cnt + STEP_W'(1);
            if (last_step) begin
              am_start <= 1'b1;
              state    <= ST_ARGMAX;
            end else begin
              state <= ST_FETCH;
            end
          end else if (wait_expired) begin
            err_timeout <= 1'b1;
            state       <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_DRAIN: begin
          if (net_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (wait_expired) begin
            err_timeout <= 1'b1;
            state       <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_ARGMAX: begin
          // Ignore a stale done while the fresh start pulse is still pending.
          if (sample_abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (am_done && !am_start) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Result is published on leaving DONE so an abort here suppresses it.
          if (!sample_abort) begin
            result_valid  <= 1'b1;
            result_class  <= am_index;
            result_counts <= counts;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_infer_sched.sv
// Self-checking bench for snn_infer_sched: a behavioural net model answers net_start with
// net_done after a configurable latency, logs every spike vector it returns, and the
// expected counts/class are derived from that log by summing and clamping.
module tb_snn_infer_sched;

  localparam int unsigned N_IN   = 30;
  localparam int unsigned N_CLS  = 5;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CW     = N_CLS * CNT_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sample_start;
  logic [STEP_W-1:0]    cfg_steps;
  logic                 sample_abort;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN-1:0]      in_bits;
  logic                 net_clear;
  logic                 net_start;
  logic [N_IN-1:0]      net_spikes_in;
  logic                 net_done;
  logic [N_CLS-1:0]     net_spikes_out;
  logic                 busy;
  logic                 result_valid;
  logic [2:0]           result_class;
  logic [CW-1:0]        result_counts;
  logic                 err_timeout;

  always #5 clk = ~clk;

  snn_infer_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_start   (sample_start),
    .cfg_steps      (cfg_steps),
    .sample_abort   (sample_abort),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_bits        (in_bits),
    .net_clear      (net_clear),
    .net_start      (net_start),
    .net_spikes_in  (net_spikes_in),
    .net_done       (net_done),
    .net_spikes_out (net_spikes_out),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_class   (result_class),
    .result_counts  (result_counts),
    .err_timeout    (err_timeout)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- net model ----------------
  int               net_mode  = 0;      // 0: respond, 1: never respond
  int               net_lat   = 0;      // 0: random latency 1..4
  bit               net_rand  = 1'b1;
  logic [N_CLS-1:0] net_fixed = '0;
  logic [N_CLS-1:0] spk_log [0:4095];
  int               spk_n       = 0;
  int               overlap_n   = 0;
  int               unstable_n  = 0;
  bit               net_running = 1'b0;

  initial begin : net_model
    logic [N_IN-1:0]  f;
    logic [N_CLS-1:0] s;
    int               lat;
    net_done       = 1'b0;
    net_spikes_out = '0;
    forever begin
      @(negedge clk);
      if (net_clear) net_running = 1'b0;
      if (net_start) begin
        if (net_running) overlap_n++;
        net_running = 1'b1;
        if (net_mode == 0) begin
          f   = net_spikes_in;
          lat = (net_lat > 0) ? net_lat : int'($urandom_range(1, 4));
          repeat (lat) begin
            @(negedge clk);
            if (net_start) overlap_n++;
            if (net_spikes_in !== f) unstable_n++;
          end
          s = net_rand ? N_CLS'($urandom) : net_fixed;
          spk_log[spk_n] = s;
          spk_n++;
          net_spikes_out = s;
          net_done       = 1'b1;
          @(negedge clk);
          net_done       = 1'b0;
          net_spikes_out = N_CLS'($urandom);
          net_running    = 1'b0;
        end
      end
    end
  end

  // ---------------- strobe monitor ----------------
  int n_clear = 0;
  int n_start = 0;
  int n_rv    = 0;
  int n_both  = 0;

  always @(negedge clk) begin
    if (net_clear) n_clear++;
    if (net_start) n_start++;
    if (result_valid) n_rv++;
    if (net_start && net_clear) n_both++;
  end

  // ---------------- reference model ----------------
  function automatic logic [CW-1:0] ref_counts(input int first, input int n);
    int            sum [N_CLS];
    logic [CW-1:0] r;
    for (int c = 0; c < int'(N_CLS); c++) sum[c] = 0;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < int'(N_CLS); c++)
        if (spk_log[first + k][c]) sum[c]++;
    r = '0;
    for (int c = 0; c < int'(N_CLS); c++)
      r[c*CNT_W +: CNT_W] = (sum[c] > 255) ? CNT_W'(255) : CNT_W'(sum[c]);
    return r;
  endfunction

  function automatic logic [2:0] ref_class(input logic [CW-1:0] cv);
    int mx;
    mx = 0;
    for (int c = 0; c < int'(N_CLS); c++)
      if (int'(cv[c*CNT_W +: CNT_W]) > mx) mx = int'(cv[c*CNT_W +: CNT_W]);
    for (int c = 0; c < int'(N_CLS); c++)
      if (int'(cv[c*CNT_W +: CNT_W]) == mx) return 3'(c);
    return 3'd0;
  endfunction

  // Start a sample and feed every frame; optional hold delays the first frame.
  task automatic run_sample(input string tag, input int steps, input int hold);
    logic [N_IN-1:0] fr;
    int              guard;
    int              s0;
    @(negedge clk);
    cfg_steps    = STEP_W'(steps);
    sample_start = 1'b1;
    @(negedge clk);
    sample_start = 1'b0;
    check({tag, "_clear_strobe"}, 64'(net_clear), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(1));
    check({tag, "_err_cleared"}, 64'(err_timeout), 64'(0));
    for (int k = 0; k < steps; k++) begin
      fr    = N_IN'($urandom);
      guard = 0;
      while (!in_ready && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check({tag, "_fetch_timeout"}, 64'(in_ready), 64'(1));
        return;
      end
      if (k == 0 && hold > 0) begin
        s0 = n_start;
        repeat (hold) @(negedge clk);
        check({tag, "_hold_no_start"}, 64'(n_start - s0), 64'(0));
        check({tag, "_hold_ready"}, 64'(in_ready), 64'(1));
      end
      in_valid = 1'b1;
      in_bits  = fr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_bits  = N_IN'($urandom);
      check({tag, "_frame"}, 64'(net_spikes_in), 64'(fr));
    end
    guard = 0;
    while (busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
    @(negedge clk);
  endtask

  task automatic sample_checked(input string tag, input int steps, input int hold);
    int            c0, s0, r0, l0;
    logic [CW-1:0] ec;
    c0 = n_clear; s0 = n_start; r0 = n_rv; l0 = spk_n;
    run_sample(tag, steps, hold);
    ec = ref_counts(l0, steps);
    check({tag, "_n_clear"}, 64'(n_clear - c0), 64'(1));
    check({tag, "_n_start"}, 64'(n_start - s0), 64'(steps));
    check({tag, "_n_result"}, 64'(n_rv - r0), 64'(1));
    check({tag, "_counts"}, 64'(result_counts), 64'(ec));
    check({tag, "_class"}, 64'(result_class), 64'(ref_class(ec)));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int   guard, cyc, s0, r0;
    logic seen_done;
    rst_n        = 1'b0;
    sample_start = 1'b0;
    cfg_steps    = '0;
    sample_abort = 1'b0;
    in_valid     = 1'b0;
    in_bits      = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_net_clear", 64'(net_clear), 64'(0));
    check("rst_net_start", 64'(net_start), 64'(0));
    check("rst_spikes_in", 64'(net_spikes_in), 64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_result_class", 64'(result_class), 64'(0));
    check("rst_result_counts", 64'(result_counts), 64'(0));
    check("rst_err", 64'(err_timeout), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three steps, class 1 fires every step.
    net_rand = 1'b0; net_fixed = 5'b00010; net_lat = 0;
    sample_checked("s3", 3, 0);
    check("s3_counts_const", 64'(result_counts), 64'(40'h00_00_00_03_00));
    check("s3_class_const", 64'(result_class), 64'(1));

    // Full-length sample with all classes firing: saturation and tie to class 0.
    net_fixed = 5'b11111; net_lat = 1;
    sample_checked("sat", 255, 0);
    check("sat_counts_const", 64'(result_counts), 64'(40'hFF_FF_FF_FF_FF));
    check("sat_class_const", 64'(result_class), 64'(0));

    // Zero-step sample goes straight to argmax.
    sample_checked("zero", 0, 0);

    // Randomised samples.
    net_rand = 1'b1; net_lat = 0;
    for (int t = 0; t < 4; t++) sample_checked("rnd", int'($urandom_range(1, 20)), 0);

    // Input withheld for 20 cycles in FETCH.
    sample_checked("hold", 2, 20);

    // Net never answers: timeout.
    net_mode = 1;
    r0 = n_rv;
    @(negedge clk);
    cfg_steps = STEP_W'(2); sample_start = 1'b1;
    @(negedge clk);
    sample_start = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    in_valid = 1'b1; in_bits = N_IN'($urandom);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!err_timeout && cyc < 1200);
    check("to_err_set", 64'(err_timeout), 64'(1));
    check("to_wait_cycles", 64'((cyc - 1) >= 1023 && (cyc - 1) <= 1025), 64'(1));
    guard = 0;
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    check("to_busy_low", 64'(busy), 64'(0));
    check("to_no_result", 64'(n_rv - r0), 64'(0));
    check("to_err_sticky", 64'(err_timeout), 64'(1));
    net_mode = 0;
    sample_checked("after_to", 3, 0);

    // Abort while waiting: drain the outstanding step, then run cleanly.
    net_lat = 4;
    s0 = n_start; r0 = n_rv;
    @(negedge clk);
    cfg_steps = STEP_W'(5); sample_start = 1'b1;
    @(negedge clk);
    sample_start = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    in_valid = 1'b1; in_bits = N_IN'($urandom);
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    sample_abort = 1'b1;
    @(posedge clk);
    #1;
    sample_abort = 1'b0;
    seen_done = 1'b0;
    guard = 0;
    while (!seen_done && guard < 20) begin
      @(negedge clk);
      #1;
      seen_done = net_done;
      guard++;
    end
    check("ab_done_seen", 64'(seen_done), 64'(1));
    check("ab_busy_at_done", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    check("ab_busy_after_done", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("ab_single_start", 64'(n_start - s0), 64'(1));
    check("ab_no_result", 64'(n_rv - r0), 64'(0));
    net_lat = 0;
    sample_checked("post_ab", 4, 0);

    // Global protocol invariants.
    check("no_start_while_running", 64'(overlap_n), 64'(0));
    check("spikes_in_stable", 64'(unstable_n), 64'(0));
    check("no_start_with_clear", 64'(n_both), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
